// File: rtl/multicycle_control_if.sv
// Control-unit bus: fetched instruction, memory handshake, flag/halt inputs,
// and the datapath control outputs, including the retired-instruction counter.
interface multicycle_control_if #(
  parameter int unsigned IW   = 32,
  parameter int unsigned ALUW = 4,
  parameter int unsigned CNTW = 16
) ();
  logic [IW-1:0]   instruction;
  logic            mem_ready;
  logic            Eq;
  logic            halt;
  logic            M1;
  logic            M2;
  logic            M3;
  logic            M4;
  logic            M5;
  logic            M6;
  logic            M7;
  logic [ALUW-1:0] ALU;
  logic            Wr_en;
  logic            ir_en;
  logic            pc_en;
  logic            flag_en;
  logic            mem_rd;
  logic            mem_wr;
  logic [CNTW-1:0] retired;
  logic            illegal;

  // Control unit side
  modport slave (
    input  instruction, mem_ready, Eq, halt,
    output M1, M2, M3, M4, M5, M6, M7, ALU, Wr_en, ir_en, pc_en, flag_en,
           mem_rd, mem_wr, retired, illegal
  );

  // Datapath / memory side
  modport master (
    output instruction, mem_ready, Eq, halt,
    input  M1, M2, M3, M4, M5, M6, M7, ALU, Wr_en, ir_en, pc_en, flag_en,
           mem_rd, mem_wr, retired, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the pierogi CPU.
// Sequences FETCH / DECODE / EXEC / MEM / WB, waits on mem_ready, counts
// retired instructions.
// Optional: define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN to park in TRAP with a
// sticky illegal flag on opcodes C-F; otherwise they behave as a NOP.
// Control outputs are decoded from state + registered opcode and forced to 0
// while rst_n is low, so no strobe can fire after reset is asserted.
module multicycle_control #(
  parameter int unsigned IW   = 32,
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.slave  ctl
);

  localparam logic [OPW-1:0] OP_AND = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_NOT = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_CMP = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_J   = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_BNE = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_LW  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_SW  = OPW'(4'hB);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OPW-1:0]  r_op;
  logic [CNTW-1:0] r_retired;

  logic [OPW-1:0]  w_op;
  logic            w_unused_bits;
  logic            w_rtype;
  logic            w_illegal_op;
  logic [ALUW-1:0] w_alu_code;

  logic            w_m1, w_m2, w_m3, w_m4, w_m5, w_m6, w_m7;
  logic [ALUW-1:0] w_alu;
  logic            w_wr_en, w_ir_en, w_pc_en, w_flag_en;
  logic            w_mem_rd, w_mem_wr, w_retire;

  assign w_op          = ctl.instruction[IW-1:IW-OPW];
  assign w_unused_bits = ^ctl.instruction[IW-OPW-1:0];
  assign w_rtype       = (r_op <= OP_SUB);
  assign w_illegal_op  = (r_op > OP_SW);
  // Opcodes 0-6 select their own ALU op; the rest compute addresses with ADD
  assign w_alu_code    = (r_op <= OP_CMP) ? ALUW'(r_op) : ALUW'(OP_ADD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Instruction register (opcode field only is needed for sequencing)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_op <= '0;
    else if (w_ir_en) r_op <= w_op;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNTW'(1);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (!ctl.halt && ctl.mem_ready) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_illegal_op) begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
          w_state_nxt = S_TRAP;
`else
          w_state_nxt = S_FETCH;
`endif
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_rtype)                            w_state_nxt = S_WB;
        else if (r_op == OP_LW || r_op == OP_SW) w_state_nxt = S_MEM;
        else                                    w_state_nxt = S_FETCH;
      end
      S_MEM: begin
        if (ctl.mem_ready) w_state_nxt = (r_op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Output decode from state + registered opcode (mem_ready/Eq qualify strobes)
  always_comb begin
    w_m1      = 1'b0;
    w_m2      = 1'b0;
    w_m3      = 1'b0;
    w_m4      = 1'b0;
    w_m5      = 1'b0;
    w_m6      = 1'b0;
    w_m7      = 1'b0;
    w_alu     = '0;
    w_wr_en   = 1'b0;
    w_ir_en   = 1'b0;
    w_pc_en   = 1'b0;
    w_flag_en = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_retire  = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          if (!ctl.halt) begin
            w_mem_rd = 1'b1;
            if (ctl.mem_ready) begin
              w_ir_en = 1'b1;
              w_pc_en = 1'b1;
            end
          end
        end
        S_EXEC: begin
          w_alu = w_alu_code;
          case (r_op)
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_SUB: w_m2 = 1'b0;
            OP_CMP: begin
              w_flag_en = 1'b1;
              w_retire  = 1'b1;
            end
            OP_J: begin
              w_pc_en  = 1'b1;
              w_m1     = 1'b1;
              w_m7     = 1'b1;
              w_retire = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
              w_pc_en  = (r_op == OP_BEQ) ? ctl.Eq : !ctl.Eq;
              w_m1     = 1'b1;
              w_m6     = 1'b1;
              w_retire = 1'b1;
            end
            OP_LW, OP_SW: begin
              w_m2 = 1'b1;
              w_m6 = 1'b1;
            end
            default: w_alu = '0;
          endcase
        end
        S_MEM: begin
          w_m4  = 1'b1;
          w_alu = w_alu_code;
          if (r_op == OP_LW) begin
            w_mem_rd = 1'b1;
          end else begin
            w_m5     = 1'b1;
            w_mem_wr = 1'b1;
            w_retire = ctl.mem_ready;
          end
        end
        S_WB: begin
          w_wr_en  = 1'b1;
          w_m3     = (r_op == OP_LW);
          w_alu    = w_alu_code;
          w_retire = 1'b1;
        end
        default: w_alu = '0;
      endcase
    end
  end

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_illegal_op) r_illegal <= 1'b1;
  end

  assign ctl.illegal = r_illegal;
`else
  assign ctl.illegal = 1'b0;
`endif

  assign ctl.M1      = w_m1;
  assign ctl.M2      = w_m2;
  assign ctl.M3      = w_m3;
  assign ctl.M4      = w_m4;
  assign ctl.M5      = w_m5;
  assign ctl.M6      = w_m6;
  assign ctl.M7      = w_m7;
  assign ctl.ALU     = w_alu;
  assign ctl.Wr_en   = w_wr_en;
  assign ctl.ir_en   = w_ir_en;
  assign ctl.pc_en   = w_pc_en;
  assign ctl.flag_en = w_flag_en;
  assign ctl.mem_rd  = w_mem_rd;
  assign ctl.mem_wr  = w_mem_wr;
  assign ctl.retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle stimulus and expected control
// vectors are queued per instruction, then replayed and compared each cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic        m1, m2, m3, m4, m5, m6, m7;
    logic [3:0]  alu;
    logic        wr_en, ir_en, pc_en, flag_en, mem_rd, mem_wr, illegal;
    logic [15:0] retired;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic        halt;
    logic        rdy;
    logic        eq;
    outs_t       exp;
  } ent_t;

  logic  clk;
  logic  rst_n;
  ent_t  sb[$];
  int    n_checks;
  int    n_err;
  string cur_name;
  logic [15:0] exp_ret;
  logic        exp_ill;

  multicycle_control_if #(.IW(32), .ALUW(4), .CNTW(16)) bus ();

  multicycle_control #(.IW(32), .OPW(4), .ALUW(4), .CNTW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t a;
    a.m1      = bus.M1;
    a.m2      = bus.M2;
    a.m3      = bus.M3;
    a.m4      = bus.M4;
    a.m5      = bus.M5;
    a.m6      = bus.M6;
    a.m7      = bus.M7;
    a.alu     = bus.ALU;
    a.wr_en   = bus.Wr_en;
    a.ir_en   = bus.ir_en;
    a.pc_en   = bus.pc_en;
    a.flag_en = bus.flag_en;
    a.mem_rd  = bus.mem_rd;
    a.mem_wr  = bus.mem_wr;
    a.illegal = bus.illegal;
    a.retired = bus.retired;
    return a;
  endfunction

  function automatic outs_t base();
    outs_t o;
    o         = '0;
    o.retired = exp_ret;
    o.illegal = exp_ill;
    return o;
  endfunction

  function automatic void push(logic [31:0] instr, logic halt, logic rdy, logic eq, outs_t o);
    ent_t e;
    e.instr = instr;
    e.halt  = halt;
    e.rdy   = rdy;
    e.eq    = eq;
    e.exp   = o;
    sb.push_back(e);
  endfunction

  // Reference sequence of one instruction: fst fetch stalls, mst memory stalls
  function automatic void push_instr(logic [3:0] op, logic eq, int fst, int mst);
    logic [31:0] ins;
    outs_t       o;
    ins = {op, 28'($urandom)};
    for (int i = 0; i < fst; i++) begin
      o = base(); o.mem_rd = 1'b1;
      push(ins, 1'b0, 1'b0, eq, o);
    end
    o = base(); o.mem_rd = 1'b1; o.ir_en = 1'b1; o.pc_en = 1'b1;
    push(ins, 1'b0, 1'b1, eq, o);
    o = base();
    push(ins, 1'b0, 1'b0, eq, o);
    if (op >= 4'hC) return;
    o = base();
    case (op)
      4'h6:    begin o.alu = 4'h6; o.flag_en = 1'b1; end
      4'h7:    begin o.alu = 4'h4; o.pc_en = 1'b1; o.m1 = 1'b1; o.m7 = 1'b1; end
      4'h8:    begin o.alu = 4'h4; o.pc_en = eq;  o.m1 = 1'b1; o.m6 = 1'b1; end
      4'h9:    begin o.alu = 4'h4; o.pc_en = !eq; o.m1 = 1'b1; o.m6 = 1'b1; end
      4'hA,
      4'hB:    begin o.alu = 4'h4; o.m2 = 1'b1; o.m6 = 1'b1; end
      default: o.alu = op;
    endcase
    push(ins, 1'b0, 1'b0, eq, o);
    if (op >= 4'h6 && op <= 4'h9) begin
      exp_ret++;
      return;
    end
    if (op <= 4'h5) begin
      o = base(); o.wr_en = 1'b1; o.alu = op;
      push(ins, 1'b0, 1'b0, eq, o);
      exp_ret++;
      return;
    end
    for (int i = 0; i <= mst; i++) begin
      o = base(); o.m4 = 1'b1; o.alu = 4'h4;
      if (op == 4'hA) o.mem_rd = 1'b1;
      else begin o.m5 = 1'b1; o.mem_wr = 1'b1; end
      push(ins, 1'b0, (i == mst), eq, o);
    end
    if (op == 4'hB) begin
      exp_ret++;
      return;
    end
    o = base(); o.wr_en = 1'b1; o.m3 = 1'b1; o.alu = 4'h4;
    push(ins, 1'b0, 1'b0, eq, o);
    exp_ret++;
  endfunction

  // Replay queued cycles: drive after negedge, compare just after
  task automatic drain_sb();
    ent_t  e;
    outs_t act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      bus.instruction = e.instr;
      bus.halt        = e.halt;
      bus.mem_ready   = e.rdy;
      bus.Eq          = e.eq;
      #1;
      act = sample();
      n_checks++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", cur_name, act, e.exp);
      end
    end
  endtask

  task automatic test_reset();
    outs_t act;
    cur_name        = "reset";
    exp_ret         = '0;
    exp_ill         = 1'b0;
    rst_n           = 1'b0;
    bus.instruction = 32'h4000_0000;
    bus.halt        = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.Eq          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    act = sample();
    n_checks++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL %s: got %h expected 0", cur_name, act);
    end
    bus.halt      = 1'b1;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic test_add();
    cur_name = "add";
    push_instr(4'h4, 1'b0, 0, 0);
    drain_sb();
  endtask

  task automatic test_branch();
    cur_name = "branch";
    push_instr(4'h8, 1'b1, 0, 0);
    push_instr(4'h9, 1'b1, 0, 0);
    drain_sb();
  endtask

  task automatic test_lw();
    cur_name = "lw_stall";
    push_instr(4'hA, 1'b0, 0, 3);
    drain_sb();
  endtask

  task automatic test_sw();
    cur_name = "sw";
    push_instr(4'hB, 1'b0, 1, 2);
    drain_sb();
  endtask

  task automatic test_illegal();
    outs_t o;
    cur_name = "illegal";
    push_instr(4'hF, 1'b0, 0, 0);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
    for (int i = 0; i < 4; i++) begin
      o = base();
      push(32'h4000_0000, 1'b0, 1'b1, 1'b0, o);
    end
    drain_sb();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ret = '0;
    exp_ill = 1'b0;
    o = sample();
    n_checks++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL %s_reset: got %h expected 0", cur_name, o);
    end
    bus.halt      = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`else
    // Back in FETCH: a stalled fetch shows mem_rd with nothing retired
    o = base(); o.mem_rd = 1'b1;
    push(32'h0, 1'b0, 1'b0, 1'b0, o);
    drain_sb();
`endif
  endtask

  task automatic test_reset_mid();
    outs_t act;
    outs_t o;
    cur_name = "reset_mid";
    push_instr(4'h4, 1'b0, 0, 0);
    // Drop the WB cycle: reset lands inside it instead
    void'(sb.pop_back());
    exp_ret--;
    drain_sb();
    @(posedge clk);
    #2;
    n_checks++;
    if (bus.Wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL %s_wb: Wr_en got %b expected 1", cur_name, bus.Wr_en);
    end
    rst_n    = 1'b0;
    bus.halt = 1'b1;
    #1;
    act = sample();
    n_checks++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL %s_out: got %h expected 0", cur_name, act);
    end
    exp_ret = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur_name = "halt";
    for (int i = 0; i < 4; i++) begin
      o = base();
      push(32'h4000_0000, 1'b1, 1'b1, 1'b0, o);
    end
    drain_sb();
  endtask

  task automatic test_back_to_back();
    cur_name = "back_to_back";
    for (int i = 0; i < 16; i++) begin
      push_instr(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    drain_sb();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_add();
    test_branch();
    test_lw();
    test_sw();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
